// File: rtl/cpu_alu_seq_if.sv
// Operand/result bundle between the CPU control FSM (master) and the registered ALU (slave).
// The state of the ALU's FSM is visible on dbg_state.
interface cpu_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             carry_in;
    logic             decimal;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             flag_n;
    logic             flag_v;
    logic             flag_z;
    logic             flag_c;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, A, B, carry_in, decimal,
        input  busy, done, out, flag_n, flag_v, flag_z, flag_c, dbg_state
    );

    modport slave (
        input  start, op, A, B, carry_in, decimal,
        output busy, done, out, flag_n, flag_v, flag_z, flag_c, dbg_state
    );
endinterface

// File: rtl/cpu_alu_seq.sv
// Registered 6502 ALU: binary ops finish in one cycle, and decimal ADC/SBC takes one BCD digit per cycle.
// Flags N/Z follow every result; C and V are held by the ops that do not define them.
module cpu_alu_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = WIDTH / 4
) (
    input logic          clk,
    input logic          rst_n,
    cpu_alu_seq_if.slave bus
);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_EOR = 4'd7;
    localparam logic [3:0] OP_ASL = 4'd8;
    localparam logic [3:0] OP_LSR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BIN = 2'd1, S_DEC = 2'd2} state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;
    logic [DW-1:0]    dig_q;
    logic             c_q;      // decimal chain: carry for ADD, not-borrow for SUB
    logic             busy_r, done_r;
    logic [WIDTH-1:0] out_r;
    logic             fn, fv, fz, fc;

    logic [WIDTH:0]   sum, diff;
    logic             v_add, v_sub;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c, bin_v;
    logic [3:0]       a_d, b_d, dig;
    logic [4:0]       dsum;
    logic [5:0]       ddiff;
    logic             dig_c;
    logic [WIDTH-1:0] dec_res;

    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ~cin_q};
        v_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        v_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        bin_res = a_q;
        bin_c   = fc;
        bin_v   = fv;
        case (op_q)
            OP_ADD: begin bin_res = sum[WIDTH-1:0];  bin_c = sum[WIDTH];   bin_v = v_add; end
            OP_SUB: begin bin_res = diff[WIDTH-1:0]; bin_c = ~diff[WIDTH]; bin_v = v_sub; end
            OP_INC: bin_res = a_q + WIDTH'(1);
            OP_DEC: bin_res = a_q - WIDTH'(1);
            OP_AND: bin_res = a_q & b_q;
            OP_OR:  bin_res = a_q | b_q;
            OP_EOR: bin_res = a_q ^ b_q;
            OP_ASL: begin bin_res = {a_q[WIDTH-2:0], 1'b0};  bin_c = a_q[WIDTH-1]; end
            OP_LSR: begin bin_res = {1'b0, a_q[WIDTH-1:1]};  bin_c = a_q[0];       end
            OP_ROL: begin bin_res = {a_q[WIDTH-2:0], cin_q}; bin_c = a_q[WIDTH-1]; end
            OP_ROR: begin bin_res = {cin_q, a_q[WIDTH-1:1]}; bin_c = a_q[0];       end
            default: bin_res = a_q;
        endcase
    end

    // One BCD digit per cycle; the result is built in place on out_r, so partial digits are visible.
    always_comb begin
        a_d   = a_q[dig_q*4 +: 4];
        b_d   = b_q[dig_q*4 +: 4];
        dsum  = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_q};
        ddiff = {2'b00, a_d} - {2'b00, b_d} - {5'b00000, ~c_q};
        dig   = dsum[3:0];
        dig_c = 1'b0;
        if (op_q == OP_ADD) begin
            if (dsum > 5'd9) begin
                dig   = dsum[3:0] + 4'd6;
                dig_c = 1'b1;
            end
        end else if (ddiff[5]) begin
            dig   = ddiff[3:0] + 4'd10;
            dig_c = 1'b0;
        end else begin
            dig   = ddiff[3:0];
            dig_c = 1'b1;
        end
        dec_res = out_r;
        dec_res[dig_q*4 +: 4] = dig;
    end

    // start is taken only while busy=0 (including the done cycle); done pulses once per accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            dig_q  <= '0;
            c_q    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            out_r  <= '0;
            fn     <= 1'b0;
            fv     <= 1'b0;
            fz     <= 1'b0;
            fc     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        cin_q  <= bus.carry_in;
                        c_q    <= bus.carry_in;
                        dig_q  <= '0;
                        busy_r <= 1'b1;
                        if (bus.decimal && (bus.op == OP_ADD || bus.op == OP_SUB))
                            state <= S_DEC;
                        else
                            state <= S_BIN;
                    end
                end
                S_BIN: begin
                    out_r  <= bin_res;
                    fn     <= bin_res[WIDTH-1];
                    fz     <= (bin_res == '0);
                    fc     <= bin_c;
                    fv     <= bin_v;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                S_DEC: begin
                    out_r <= dec_res;
                    c_q   <= dig_c;
                    dig_q <= dig_q + 1'b1;
                    if (dig_q == DW'(DIGITS - 1)) begin
                        fn     <= dec_res[WIDTH-1];
                        fz     <= (dec_res == '0);
                        fc     <= dig_c;
                        fv     <= (op_q == OP_ADD) ? v_add : v_sub;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out       = out_r;
    assign bus.flag_n    = fn;
    assign bus.flag_v    = fv;
    assign bus.flag_z    = fz;
    assign bus.flag_c    = fc;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_cpu_alu_seq.sv
// Bench for cpu_alu_seq at WIDTH=8 and WIDTH=16, checked against an arithmetic reference model.
module tb_cpu_alu_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_alu_seq_if #(.WIDTH(8))  bus8 ();
    cpu_alu_seq_if #(.WIDTH(16)) bus16 ();

    cpu_alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    cpu_alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int n_checks = 0;
    int n_err    = 0;
    bit m8_n, m8_v, m8_z, m8_c;
    bit m16_n, m16_v, m16_z, m16_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op definitions; flags carried across calls.
    task automatic model(input int w, input int op, input longint a, input longint b,
                         input int cin, input int dec,
                         inout bit fn, inout bit fv, inout bit fz, inout bit fc,
                         output longint res, output int lat);
        longint m, half, r, sa, sb, s, t, dg;
        int c;
        m    = longint'(1) << w;
        half = m / 2;
        lat  = 1;
        res  = a;
        case (op)
            1, 2: begin
                sa = (a >= half) ? a - m : a;
                sb = (b >= half) ? b - m : b;
                if (op == 1) begin r = a + b + cin;       s = sa + sb + cin;       end
                else         begin r = a - b - (1 - cin); s = sa - sb - (1 - cin); end
                fv = (s < -half) || (s >= half);
                if (dec != 0) begin
                    c   = (op == 1) ? cin : 1 - cin;
                    res = 0;
                    for (int i = 0; i < w / 4; i++) begin
                        if (op == 1) begin
                            t = ((a >> (4 * i)) % 16) + ((b >> (4 * i)) % 16) + c;
                            if (t > 9) begin dg = (t + 6) & 15; c = 1; end
                            else       begin dg = t;            c = 0; end
                        end else begin
                            t = ((a >> (4 * i)) % 16) - ((b >> (4 * i)) % 16) - c;
                            if (t < 0) begin dg = (t + 10) & 15; c = 1; end
                            else       begin dg = t;             c = 0; end
                        end
                        res = res + (dg << (4 * i));
                    end
                    fc  = (op == 1) ? (c == 1) : (c == 0);
                    lat = w / 4;
                end else begin
                    res = ((r % m) + m) % m;
                    fc  = (op == 1) ? (r >= m) : (r >= 0);
                end
            end
            3:  res = (a + 1) % m;
            4:  res = (a - 1 + m) % m;
            5:  res = a & b;
            6:  res = a | b;
            7:  res = a ^ b;
            8:  begin fc = (a >= half); res = (a * 2) % m;       end
            9:  begin fc = (a % 2) == 1; res = a / 2;            end
            10: begin fc = (a >= half); res = (a * 2 + cin) % m; end
            11: begin fc = (a % 2) == 1; res = a / 2 + cin * half; end
            default: res = a;
        endcase
        fn = (res >= half);
        fz = (res == 0);
    endtask

    task automatic run8(input string tag, input int op, input longint a, input longint b,
                        input int cin, input int dec);
        longint er;
        int elat, lat;
        model(8, op, a, b, cin, dec, m8_n, m8_v, m8_z, m8_c, er, elat);
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = 4'(op); bus8.A = 8'(a); bus8.B = 8'(b);
        bus8.carry_in = cin[0]; bus8.decimal = dec[0];
        @(negedge clk);
        bus8.start = 1'b0;
        chk($sformatf("%s.busy", tag), bus8.busy, 1);
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s.lat", tag), lat, elat);
        chk($sformatf("%s.out", tag), bus8.out, er);
        chk($sformatf("%s.n", tag), bus8.flag_n, m8_n);
        chk($sformatf("%s.v", tag), bus8.flag_v, m8_v);
        chk($sformatf("%s.z", tag), bus8.flag_z, m8_z);
        chk($sformatf("%s.c", tag), bus8.flag_c, m8_c);
        @(negedge clk);
        chk($sformatf("%s.pulse", tag), bus8.done, 0);
        chk($sformatf("%s.idle", tag), bus8.busy, 0);
    endtask

    task automatic run16(input string tag, input int op, input longint a, input longint b,
                         input int cin, input int dec);
        longint er;
        int elat, lat;
        model(16, op, a, b, cin, dec, m16_n, m16_v, m16_z, m16_c, er, elat);
        @(negedge clk);
        bus16.start = 1'b1; bus16.op = 4'(op); bus16.A = 16'(a); bus16.B = 16'(b);
        bus16.carry_in = cin[0]; bus16.decimal = dec[0];
        @(negedge clk);
        bus16.start = 1'b0;
        lat = 0;
        while (bus16.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s.lat", tag), lat, elat);
        chk($sformatf("%s.out", tag), bus16.out, er);
        chk($sformatf("%s.nvzc", tag), {bus16.flag_n, bus16.flag_v, bus16.flag_z, bus16.flag_c},
            {m16_n, m16_v, m16_z, m16_c});
        @(negedge clk);
        chk($sformatf("%s.pulse", tag), bus16.done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint er;
        int elat;
        bus8.start = 0;  bus8.op = 0;  bus8.A = 0;  bus8.B = 0;  bus8.carry_in = 0;  bus8.decimal = 0;
        bus16.start = 0; bus16.op = 0; bus16.A = 0; bus16.B = 0; bus16.carry_in = 0; bus16.decimal = 0;
        repeat (3) @(negedge clk);
        chk("reset.out", bus8.out, 0);
        chk("reset.flags", {bus8.flag_n, bus8.flag_v, bus8.flag_z, bus8.flag_c}, 0);
        chk("reset.busy", bus8.busy, 0);
        chk("reset.done", bus8.done, 0);
        rst_n = 1'b1;

        run8("add_ovf", 1, 'h50, 'h50, 0, 0);
        run8("sub_borrow", 2, 'h00, 'h01, 1, 0);
        run8("inc_wrap", 3, 'hFF, 'h00, 0, 0);
        run8("dadd", 1, 'h58, 'h46, 1, 1);
        run8("dsub", 2, 'h10, 'h01, 1, 1);
        run8("ror", 11, 'h01, 'h00, 1, 0);
        run8("asl", 8, 'h80, 'h00, 0, 0);
        run8("rol", 10, 'h81, 'h00, 1, 0);
        run8("lsr", 9, 'h03, 'h00, 0, 0);
        run8("pass_hi_op", 14, 'h7E, 'h11, 1, 1);

        // start held high with changing operands: only the first request runs
        model(8, 1, 'h12, 'h34, 0, 1, m8_n, m8_v, m8_z, m8_c, er, elat);
        @(negedge clk);
        bus8.start = 1; bus8.op = 4'd1; bus8.A = 8'h12; bus8.B = 8'h34; bus8.carry_in = 0; bus8.decimal = 1;
        @(negedge clk);
        bus8.A = 8'h99; bus8.B = 8'h99; bus8.op = 4'd5;
        chk("hold.busy", bus8.busy, 1);
        @(negedge clk);
        bus8.A = 8'h77;
        chk("hold.early_done", bus8.done, 0);
        @(negedge clk);
        chk("hold.done", bus8.done, 1);
        chk("hold.out", bus8.out, er);
        chk("hold.c", bus8.flag_c, m8_c);
        bus8.start = 0;
        @(negedge clk);
        chk("hold.no_repeat", bus8.done, 0);
        chk("hold.idle", bus8.busy, 0);

        // back-to-back: second start is accepted in the done cycle of the first
        model(8, 1, 'h7F, 'h01, 0, 0, m8_n, m8_v, m8_z, m8_c, er, elat);
        @(negedge clk);
        bus8.start = 1; bus8.op = 4'd1; bus8.A = 8'h7F; bus8.B = 8'h01; bus8.carry_in = 0; bus8.decimal = 0;
        @(negedge clk);
        bus8.op = 4'd7; bus8.A = 8'hF0; bus8.B = 8'hFF;
        @(negedge clk);
        chk("b2b.done1", bus8.done, 1);
        chk("b2b.out1", bus8.out, er);
        chk("b2b.v1", bus8.flag_v, m8_v);
        model(8, 7, 'hF0, 'hFF, 0, 0, m8_n, m8_v, m8_z, m8_c, er, elat);
        @(negedge clk);
        bus8.start = 0;
        chk("b2b.gap", bus8.done, 0);
        chk("b2b.busy2", bus8.busy, 1);
        @(negedge clk);
        chk("b2b.done2", bus8.done, 1);
        chk("b2b.out2", bus8.out, er);
        chk("b2b.nvzc2", {bus8.flag_n, bus8.flag_v, bus8.flag_z, bus8.flag_c}, {m8_n, m8_v, m8_z, m8_c});
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            run8($sformatf("rnd%0d", i), int'($urandom_range(0, 15)), longint'($urandom_range(0, 255)),
                 longint'($urandom_range(0, 255)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        // reset in the middle of a decimal operation
        @(negedge clk);
        bus8.start = 1; bus8.op = 4'd1; bus8.A = 8'h58; bus8.B = 8'h46; bus8.carry_in = 1; bus8.decimal = 1;
        @(negedge clk);
        bus8.start = 0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.out", bus8.out, 0);
        chk("abort.flags", {bus8.flag_n, bus8.flag_v, bus8.flag_z, bus8.flag_c}, 0);
        chk("abort.busy", bus8.busy, 0);
        chk("abort.done", bus8.done, 0);
        rst_n = 1'b1;
        {m8_n, m8_v, m8_z, m8_c} = 4'b0;
        {m16_n, m16_v, m16_z, m16_c} = 4'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort.quiet%0d", i), bus8.done, 0);
        end

        run16("w16_dadd", 1, 'h9999, 'h0001, 0, 1);
        for (int i = 0; i < 20; i++) begin
            run16($sformatf("w16_rnd%0d", i), int'($urandom_range(0, 15)), longint'($urandom_range(0, 65535)),
                  longint'($urandom_range(0, 65535)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
